branch_history_table: RTL and testbench
=======================================

Name: branch_history_table

Overview:
Dynamic branch predictor for the 5-stage pipeline. It is a small fully-associative table, keyed by the 12-bit PC+4 of branch/jump instructions, that stores a branch target and a 2-bit saturating counter per entry.
- IF stage queries it combinationally with the current PC+4 and gets a predicted next address.
- EXE stage writes back each resolved branch/jump outcome one per cycle.

Parameters:
ENTRIES, 8, number of table entries (power of two, ≥2)
ADDR_W, 12, byte-address width of PCs/targets
CNT_INIT, 2'b10, counter value given to a newly allocated entry (weakly taken)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
insert_ins_addr  input  ADDR_W  PC+4 of the branch resolved in EXE (lookup key)
insert_ins_next_addr  input  ADDR_W  resolved next PC from EXE (target when taken)
is_branch  input  1  EXE holds a branch/jump this cycle; enables update
is_suc  input  1  branch taken (unconditional jumps always 1)
query_ins_addr  input  ADDR_W  PC+4 of instruction in IF
predict_addr  output  ADDR_W  predicted target
predict_jump  output  1  1 = IF must select predict_addr instead of PC+4

Behaviour:
- Entry state: valid(1), tag(ADDR_W), target(ADDR_W), cnt(2). Replacement pointer rp is log2(ENTRIES) bits.
- Reset (rst=0, asynchronous): all valid=0, tag/target/cnt=0, rp=0. Outputs therefore go to predict_jump=0 and predict_addr=0 immediately. Reset held mid-operation keeps the table cleared and overrides any insert.

Query (purely combinational, zero latency):
- Hit = valid entry with tag == query_ins_addr. Tags are unique, so at most one entry hits.
- Hit and cnt[1]=1: predict_jump=1, predict_addr=target.
- Hit and cnt[1]=0: predict_jump=0, predict_addr=target.
- Miss: predict_jump=0, predict_addr=0.

Update (rising edge, only when is_branch=1 and rst=1):
- Hit on insert_ins_addr, is_suc=1: cnt = min(cnt+1, 3); target <= insert_ins_next_addr.
- Hit, is_suc=0: cnt = max(cnt-1, 0); target unchanged.
- Miss, is_suc=1: allocate an entry.
  - Victim is the lowest-index invalid entry if any exists; otherwise entry rp, after which rp increments modulo ENTRIES.
  - rp advances only when a valid entry is evicted.
  - New entry: valid=1, tag=insert_ins_addr, target=insert_ins_next_addr, cnt=CNT_INIT.
- Miss, is_suc=0: no change.
- is_branch=0: no change, regardless of is_suc.

Boundary conditions:
- Counter saturates at 0 and 3; no wrap.
- A query and an insert to the same address in the same cycle: the query returns pre-update state. The new state is visible from the next cycle.
- When the table is full, allocation evicts in round-robin order.
- No stall/flush input. The pipeline supplies is_branch=0 for bubbles.

Test Plan:
1. Reset: drive rst=0 asynchronously mid-cycle, then query any address -> predict_jump=0 and predict_addr=0 immediately. After release, every query still misses.
2. Allocation/predict: one cycle with is_branch=1, is_suc=1, insert 0x014 -> next 0x040. Next cycle, query 0x014 -> predict_jump=1, predict_addr=0x040 (cnt=2). Before the edge, the same-cycle query returns predict_jump=0.
3. Counter hysteresis: starting from test 2's entry, apply two not-taken updates -> cnt=0 and predict_jump=0, predict_addr stays 0x040. One taken update -> cnt=1, still 0. A second taken update -> cnt=2, predict_jump=1. Three more taken updates -> cnt saturates at 3. Then one not-taken update -> cnt=2, still predicts taken.
4. Target refresh: taken update on 0x014 with next=0x080 -> subsequent query returns predict_addr=0x080.
5. Not-taken miss: is_branch=1, is_suc=0 on an unseen 0x100 -> query 0x100 misses (jump=0, addr=0). is_suc=1 with is_branch=0 also produces no allocation.
6. Replacement: allocate 8 distinct taken branches 0x004..0x020, all of which hit. A 9th (0x024) evicts 0x004 and a 10th (0x028) evicts 0x008; the remaining entries still hit with their targets intact.

Source files
------------

// File: rtl/branch_history_table.sv
// Fully-associative branch history table: combinational IF-stage prediction,
// one resolved branch/jump written back from EXE per cycle.
module branch_history_table #(
  parameter int         ENTRIES  = 8,
  parameter int         ADDR_W   = 12,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] insert_ins_addr,
  input  logic [ADDR_W-1:0] insert_ins_next_addr,
  input  logic              is_branch,
  input  logic              is_suc,
  input  logic [ADDR_W-1:0] query_ins_addr,
  output logic [ADDR_W-1:0] predict_addr,
  output logic              predict_jump
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic              r_valid  [ENTRIES];
  logic [ADDR_W-1:0] r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [1:0]        r_cnt    [ENTRIES];
  logic [IDX_W-1:0]  r_rp;

  logic              w_q_hit;
  logic              w_q_taken;
  logic [ADDR_W-1:0] w_q_target;

  logic              w_ins_hit;
  logic [IDX_W-1:0]  w_ins_idx;
  logic              w_has_free;
  logic [IDX_W-1:0]  w_free_idx;
  logic [IDX_W-1:0]  w_victim;
  logic [1:0]        w_cnt_next;

  // Query reads only registered state, so a same-cycle insert is not visible yet.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_q_hit    = 1'b0;
    w_q_taken  = 1'b0;
    w_q_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == query_ins_addr)) begin
        w_q_hit    = 1'b1;
        w_q_taken  = r_cnt[i][1];
        w_q_target = r_target[i];
      end
    end
  end

  assign predict_jump = w_q_hit & w_q_taken;
  assign predict_addr = w_q_target;

  always_comb begin
    w_ins_hit = 1'b0;
    w_ins_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == insert_ins_addr)) begin
        w_ins_hit = 1'b1;
        w_ins_idx = IDX_W'(i);
      end
    end
  end

  // Scan downward so the lowest-index invalid entry is the last one written.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_victim = w_has_free ? w_free_idx : r_rp;

  always_comb begin
    w_cnt_next = r_cnt[w_ins_idx];
    if (is_suc) begin
      if (r_cnt[w_ins_idx] != 2'b11) w_cnt_next = r_cnt[w_ins_idx] + 2'b01;
    end else begin
      if (r_cnt[w_ins_idx] != 2'b00) w_cnt_next = r_cnt[w_ins_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table itself is reset, not just valid bits, so a cleared
      // table reports predict_addr=0 and no stale target can leak out.
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_rp <= '0;
    end else if (is_branch) begin
      // NOTE: non-blocking assignments keep every entry update based on pre-edge state.
      if (w_ins_hit) begin
        r_cnt[w_ins_idx] <= w_cnt_next;
        if (is_suc) r_target[w_ins_idx] <= insert_ins_next_addr;
      end else if (is_suc) begin
        r_valid[w_victim]  <= 1'b1;
        r_tag[w_victim]    <= insert_ins_addr;
        r_target[w_victim] <= insert_ins_next_addr;
        r_cnt[w_victim]    <= CNT_INIT;
        // Round-robin pointer moves only when a live entry is evicted.
        if (!w_has_free) r_rp <= r_rp + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed self-checking bench for branch_history_table: reset, allocation,
// counter hysteresis/saturation, target refresh, non-allocation and replacement.
module tb_branch_history_table;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] insert_ins_addr;
  logic [ADDR_W-1:0] insert_ins_next_addr;
  logic              is_branch;
  logic              is_suc;
  logic [ADDR_W-1:0] query_ins_addr;
  logic [ADDR_W-1:0] predict_addr;
  logic              predict_jump;

  int n_checks = 0;
  int n_fail   = 0;

  branch_history_table #(
    .ENTRIES (8),
    .ADDR_W  (ADDR_W),
    .CNT_INIT(2'b10)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .insert_ins_addr     (insert_ins_addr),
    .insert_ins_next_addr(insert_ins_next_addr),
    .is_branch           (is_branch),
    .is_suc              (is_suc),
    .query_ins_addr      (query_ins_addr),
    .predict_addr        (predict_addr),
    .predict_jump        (predict_jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ADDR_W-1:0] obs,
                       input logic [ADDR_W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational query: drive address, let it settle, compare both outputs.
  task automatic query(input string tag, input logic [ADDR_W-1:0] addr,
                       input logic exp_jump, input logic [ADDR_W-1:0] exp_addr);
    query_ins_addr = addr;
    #1;
    check({tag, ".jump"}, ADDR_W'(predict_jump), ADDR_W'(exp_jump));
    check({tag, ".addr"}, predict_addr, exp_addr);
  endtask

  // One EXE write-back cycle, driven at the falling edge and applied at the rising edge.
  task automatic upd(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] nxt,
                     input logic br, input logic suc);
    @(negedge clk);
    insert_ins_addr      = addr;
    insert_ins_next_addr = nxt;
    is_branch            = br;
    is_suc               = suc;
    @(posedge clk);
    #1;
    is_branch = 1'b0;
    is_suc    = 1'b0;
  endtask

  initial begin
    rst                  = 1'b0;
    insert_ins_addr      = '0;
    insert_ins_next_addr = '0;
    is_branch            = 1'b0;
    is_suc               = 1'b0;
    query_ins_addr       = '0;

    // Reset state
    #2;
    query("reset_hold", 12'h014, 1'b0, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    query("post_reset_014", 12'h014, 1'b0, 12'h000);
    query("post_reset_000", 12'h000, 1'b0, 12'h000);

    // Allocation: same-cycle query sees the old (empty) state
    @(negedge clk);
    insert_ins_addr      = 12'h014;
    insert_ins_next_addr = 12'h040;
    is_branch            = 1'b1;
    is_suc               = 1'b1;
    query("alloc_same_cycle", 12'h014, 1'b0, 12'h000);
    @(posedge clk);
    #1;
    is_branch = 1'b0;
    is_suc    = 1'b0;
    query("alloc_next_cycle", 12'h014, 1'b1, 12'h040);

    // Counter hysteresis and saturation (cnt starts at 2)
    upd(12'h014, 12'h040, 1'b1, 1'b0);
    query("nt1_cnt1", 12'h014, 1'b0, 12'h040);
    upd(12'h014, 12'h040, 1'b1, 1'b0);
    query("nt2_cnt0", 12'h014, 1'b0, 12'h040);
    upd(12'h014, 12'h040, 1'b1, 1'b0);
    query("nt3_sat0", 12'h014, 1'b0, 12'h040);
    upd(12'h014, 12'h040, 1'b1, 1'b1);
    query("t1_cnt1", 12'h014, 1'b0, 12'h040);
    upd(12'h014, 12'h040, 1'b1, 1'b1);
    query("t2_cnt2", 12'h014, 1'b1, 12'h040);
    upd(12'h014, 12'h040, 1'b1, 1'b1);
    upd(12'h014, 12'h040, 1'b1, 1'b1);
    upd(12'h014, 12'h040, 1'b1, 1'b1);
    query("t5_sat3", 12'h014, 1'b1, 12'h040);
    upd(12'h014, 12'h040, 1'b1, 1'b0);
    query("sat3_nt_cnt2", 12'h014, 1'b1, 12'h040);

    // Target refresh on a taken hit
    upd(12'h014, 12'h080, 1'b1, 1'b1);
    query("target_refresh", 12'h014, 1'b1, 12'h080);

    // Not-taken miss and bubble never allocate
    upd(12'h100, 12'h300, 1'b1, 1'b0);
    query("nt_miss_no_alloc", 12'h100, 1'b0, 12'h000);
    upd(12'h100, 12'h300, 1'b0, 1'b1);
    query("bubble_no_alloc", 12'h100, 1'b0, 12'h000);
    upd(12'h014, 12'h0F0, 1'b0, 1'b0);
    query("bubble_no_update", 12'h014, 1'b1, 12'h080);

    // Asynchronous reset mid-cycle with an insert pending
    @(negedge clk);
    insert_ins_addr      = 12'h200;
    insert_ins_next_addr = 12'h222;
    is_branch            = 1'b1;
    is_suc               = 1'b1;
    #1;
    rst = 1'b0;
    query("async_reset_now", 12'h014, 1'b0, 12'h000);
    @(posedge clk);
    #1;
    query("reset_blocks_insert", 12'h200, 1'b0, 12'h000);
    @(negedge clk);
    is_branch = 1'b0;
    is_suc    = 1'b0;
    rst       = 1'b1;
    query("after_reset_014", 12'h014, 1'b0, 12'h000);
    query("after_reset_200", 12'h200, 1'b0, 12'h000);

    // Fill the table from empty: entries 0..7 get 0x004..0x020
    for (int i = 1; i <= 8; i++)
      upd(ADDR_W'(4 * i), ADDR_W'(12'h100 + 4 * i), 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++)
      query($sformatf("fill_%0d", i), ADDR_W'(4 * i), 1'b1, ADDR_W'(12'h100 + 4 * i));

    // Full table: round-robin eviction starting at entry 0
    upd(12'h024, 12'h124, 1'b1, 1'b1);
    query("evict9_new", 12'h024, 1'b1, 12'h124);
    query("evict9_old", 12'h004, 1'b0, 12'h000);
    query("evict9_keep", 12'h008, 1'b1, 12'h108);
    upd(12'h028, 12'h128, 1'b1, 1'b1);
    query("evict10_new", 12'h028, 1'b1, 12'h128);
    query("evict10_old", 12'h008, 1'b0, 12'h000);
    for (int i = 3; i <= 8; i++)
      query($sformatf("survivor_%0d", i), ADDR_W'(4 * i), 1'b1, ADDR_W'(12'h100 + 4 * i));
    upd(12'h02C, 12'h12C, 1'b1, 1'b1);
    query("evict11_old", 12'h00C, 1'b0, 12'h000);
    query("evict11_new", 12'h02C, 1'b1, 12'h12C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
